// File: rtl/stage_decode.sv
// ID stage of the RV32I pipeline: decode, branch/jump resolution, load-use stall, ID-EX register (build option: CTRL_MISALIGN_EXC_EN).
// Latency: redirect, stall and squash are combinational in the ID cycle; the ID-EX register updates one cycle later.
// Backpressure: backend_stall_i freezes ID-EX. Any stall latches the imem word in the hold register.
module stage_decode #(
    parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_pc_plus_four_i,
    input  logic [31:0] imem_data_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        backend_stall_i,
    output logic        stall_o,
    output logic        squash_o,
    output logic        instr_jal_o,
    output logic        instr_jalr_o,
    output logic        branch_taken_o,
    output logic [31:0] jal_addr_o,
    output logic [31:0] jalr_addr_o,
    output logic [31:0] branch_addr_o,
    output logic        id_ex_valid_o,
    output logic [31:0] id_ex_pc_o,
    output logic [31:0] id_ex_pc_plus_four_o,
    output logic [31:0] id_ex_instr_o,
    output logic [31:0] id_ex_rs1_data_o,
    output logic [31:0] id_ex_rs2_data_o,
    output logic [31:0] id_ex_imm_o,
    output logic [4:0]  id_ex_rd_o,
    output logic        id_ex_illegal_o,
    output logic        id_ex_exc_o
);

    localparam logic [0:0] S_LIVE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [0:0]  held_q;
    logic [31:0] hold_r;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm;
    logic        illegal, writes_rd, uses_rs1, uses_rs2;
    logic        is_jal, is_jalr, is_branch, br_cond;
    logic        lu, redir_ok, ctrl_exc;
    logic [4:0]  rd_eff;

    // The sync RAM word is gone one cycle after a stall starts, so the held copy wins while HELD
    assign instr  = (held_q == S_HELD) ? hold_r : imem_data_i;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1_addr_o = instr[19:15];
    assign rs2_addr_o = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Opcode/funct3 classification: immediate format, legality and register usage
    always_comb begin
        imm       = 32'h0;
        illegal   = 1'b0;
        writes_rd = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin imm = imm_u; writes_rd = 1'b1; uses_rs1 = 1'b0; end
            OP_JAL:   begin imm = imm_j; writes_rd = 1'b1; uses_rs1 = 1'b0; is_jal = 1'b1; end
            OP_JALR:  begin
                imm = imm_i;
                illegal   = (funct3 != 3'b000);
                writes_rd = ~illegal;
                is_jalr   = ~illegal;
            end
            OP_BRANCH: begin
                imm = imm_b; uses_rs2 = 1'b1;
                illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
                is_branch = ~illegal;
            end
            OP_LOAD:  begin
                imm = imm_i;
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                writes_rd = ~illegal;
            end
            OP_STORE: begin imm = imm_s; uses_rs2 = 1'b1; illegal = (funct3 > 3'b010); end
            OP_IMM:   begin imm = imm_i; writes_rd = 1'b1; end
            OP_OP:    begin writes_rd = 1'b1; uses_rs2 = 1'b1; end
            OP_FENCE, OP_SYSTEM: begin imm = imm_i; illegal = (funct3 != 3'b000); end
            default:  illegal = 1'b1;
        endcase
    end

    // Branch condition on the already-forwarded operands
    always_comb begin
        case (funct3)
            3'b000:  br_cond = (rs1_data_i == rs2_data_i);
            3'b001:  br_cond = (rs1_data_i != rs2_data_i);
            3'b100:  br_cond = ($signed(rs1_data_i) <  $signed(rs2_data_i));
            3'b101:  br_cond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            3'b110:  br_cond = (rs1_data_i <  rs2_data_i);
            3'b111:  br_cond = (rs1_data_i >= rs2_data_i);
            default: br_cond = 1'b0;
        endcase
    end

    assign jal_addr_o    = if_pc_i + imm_j;
    assign branch_addr_o = if_pc_i + imm_b;
    assign jalr_addr_o   = (rs1_data_i + imm_i) & ~32'h1;

    assign lu = if_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) &
                ((uses_rs1 & (rs1_addr_o == ex_rd_i)) | (uses_rs2 & (rs2_addr_o == ex_rd_i)));
    assign stall_o  = lu | backend_stall_i;
    assign redir_ok = if_valid_i & ~stall_o;

`ifdef CTRL_MISALIGN_EXC_EN
    // A half-word aligned target traps in EX instead of redirecting fetch
    assign ctrl_exc = (is_jal & jal_addr_o[1]) | (is_jalr & jalr_addr_o[1]) |
                      (is_branch & br_cond & branch_addr_o[1]);
`else
    assign ctrl_exc = 1'b0;
`endif

    assign instr_jal_o    = redir_ok & is_jal & ~ctrl_exc;
    assign instr_jalr_o   = redir_ok & is_jalr & ~ctrl_exc;
    assign branch_taken_o = redir_ok & is_branch & br_cond & ~ctrl_exc;
    assign squash_o       = instr_jal_o | instr_jalr_o | branch_taken_o;
    assign rd_eff         = (writes_rd & ~ctrl_exc) ? instr[11:7] : 5'd0;

    // Hold FSM: latch the imem word on the first stalled cycle, release once the stall drops
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            held_q <= S_LIVE;
            hold_r <= RESET_NOP;
        end else if (stall_o) begin
            held_q <= S_HELD;
            if (held_q == S_LIVE) hold_r <= imem_data_i;
        end else begin
            held_q <= S_LIVE;
        end
    end

    // ID-EX register: freeze on backpressure, bubble on load-use, otherwise load
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            id_ex_valid_o        <= 1'b0;
            id_ex_pc_o           <= 32'h0;
            id_ex_pc_plus_four_o <= 32'h0;
            id_ex_instr_o        <= 32'h0;
            id_ex_rs1_data_o     <= 32'h0;
            id_ex_rs2_data_o     <= 32'h0;
            id_ex_imm_o          <= 32'h0;
            id_ex_rd_o           <= 5'd0;
            id_ex_illegal_o      <= 1'b0;
            id_ex_exc_o          <= 1'b0;
        end else if (backend_stall_i) begin
            id_ex_valid_o <= id_ex_valid_o;
        end else if (lu) begin
            id_ex_valid_o <= 1'b0;
        end else begin
            id_ex_valid_o        <= if_valid_i;
            id_ex_pc_o           <= if_pc_i;
            id_ex_pc_plus_four_o <= if_pc_plus_four_i;
            id_ex_instr_o        <= instr;
            id_ex_rs1_data_o     <= rs1_data_i;
            id_ex_rs2_data_o     <= rs2_data_i;
            id_ex_imm_o          <= imm;
            id_ex_rd_o           <= rd_eff;
            id_ex_illegal_o      <= illegal;
            id_ex_exc_o          <= ctrl_exc;
        end
    end

endmodule

// File: tb/tb_stage_decode.sv
// Self-checking bench for stage_decode: directed vector table, multi-cycle stall sequences, random vs reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled before the next edge or 1 unit after it.
// Honours CTRL_MISALIGN_EXC_EN to pick the expected behaviour for misaligned control-flow targets.
module tb_stage_decode;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_valid_i;
    logic [31:0] if_pc_i, if_pc_plus_four_i, imem_data_i;
    logic [4:0]  rs1_addr_o, rs2_addr_o;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic        ex_mem_read_i;
    logic [4:0]  ex_rd_i;
    logic        backend_stall_i;
    logic        stall_o, squash_o, instr_jal_o, instr_jalr_o, branch_taken_o;
    logic [31:0] jal_addr_o, jalr_addr_o, branch_addr_o;
    logic        id_ex_valid_o;
    logic [31:0] id_ex_pc_o, id_ex_pc_plus_four_o, id_ex_instr_o;
    logic [31:0] id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o;
    logic [4:0]  id_ex_rd_o;
    logic        id_ex_illegal_o, id_ex_exc_o;

    always #5 clk = ~clk;

    stage_decode dut (
        .clk(clk), .rst_ni(rst_ni), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
        .if_pc_plus_four_i(if_pc_plus_four_i), .imem_data_i(imem_data_i),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_rd_i(ex_rd_i), .backend_stall_i(backend_stall_i),
        .stall_o(stall_o), .squash_o(squash_o), .instr_jal_o(instr_jal_o),
        .instr_jalr_o(instr_jalr_o), .branch_taken_o(branch_taken_o),
        .jal_addr_o(jal_addr_o), .jalr_addr_o(jalr_addr_o), .branch_addr_o(branch_addr_o),
        .id_ex_valid_o(id_ex_valid_o), .id_ex_pc_o(id_ex_pc_o),
        .id_ex_pc_plus_four_o(id_ex_pc_plus_four_o), .id_ex_instr_o(id_ex_instr_o),
        .id_ex_rs1_data_o(id_ex_rs1_data_o), .id_ex_rs2_data_o(id_ex_rs2_data_o),
        .id_ex_imm_o(id_ex_imm_o), .id_ex_rd_o(id_ex_rd_o),
        .id_ex_illegal_o(id_ex_illegal_o), .id_ex_exc_o(id_ex_exc_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exr, input logic [4:0] exrd, input logic bs);
        if_valid_i = v; if_pc_i = pc; if_pc_plus_four_i = pc + 32'd4; imem_data_i = ins;
        rs1_data_i = a; rs2_data_i = b; ex_mem_read_i = exr; ex_rd_i = exrd; backend_stall_i = bs;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decode straight from the RV32I rules
    typedef struct {
        logic stall, squash, jal, jalr, br, lu, ill, exc;
        logic [31:0] jal_a, jalr_a, br_a, imm;
        logic [4:0] rd;
    } ref_t;

    function automatic ref_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] a, input logic [31:0] b, input logic v,
                                        input logic exr, input logic [4:0] exrd, input logic bs);
        ref_t r;
        logic [6:0] opc = ins[6:0];
        int f3 = int'(ins[14:12]);
        logic [31:0] iI = 32'($signed(ins[31:20]));
        logic [31:0] iS = 32'($signed({ins[31:25], ins[11:7]}));
        logic [31:0] iB = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        logic [31:0] iJ = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        logic [31:0] iU = {ins[31:12], 12'h000};
        logic writes = 0, u1 = 1, u2 = 0, jal = 0, jalr = 0, br = 0, take = 0, mis = 0, ok;
        r.ill = 0; r.imm = 0;
        case (opc)
            7'h37, 7'h17: begin r.imm = iU; writes = 1; u1 = 0; end
            7'h6F: begin r.imm = iJ; writes = 1; u1 = 0; jal = 1; end
            7'h67: begin r.imm = iI; r.ill = (f3 != 0); writes = !r.ill; jalr = !r.ill; end
            7'h63: begin r.imm = iB; u2 = 1; r.ill = (f3 == 2 || f3 == 3); br = !r.ill; end
            7'h03: begin r.imm = iI; r.ill = !(f3 inside {0, 1, 2, 4, 5}); writes = !r.ill; end
            7'h23: begin r.imm = iS; u2 = 1; r.ill = (f3 > 2); end
            7'h13: begin r.imm = iI; writes = 1; end
            7'h33: begin writes = 1; u2 = 1; end
            7'h0F, 7'h73: begin r.imm = iI; r.ill = (f3 != 0); end
            default: r.ill = 1;
        endcase
        case (f3)
            0: take = (a == b);
            1: take = (a != b);
            4: take = ($signed(a) < $signed(b));
            5: take = ($signed(a) >= $signed(b));
            6: take = (a < b);
            7: take = (a >= b);
            default: take = 0;
        endcase
        r.jal_a  = pc + iJ;
        r.br_a   = pc + iB;
        r.jalr_a = (a + iI) & 32'hFFFF_FFFE;
`ifdef CTRL_MISALIGN_EXC_EN
        mis = (jal && r.jal_a[1]) || (jalr && r.jalr_a[1]) || (br && take && r.br_a[1]);
`endif
        r.exc = mis;
        r.lu = v && exr && exrd != 0 && ((u1 && ins[19:15] == exrd) || (u2 && ins[24:20] == exrd));
        r.stall = r.lu || bs;
        ok = v && !r.stall && !mis;
        r.jal = ok && jal;
        r.jalr = ok && jalr;
        r.br = ok && br && take;
        r.squash = r.jal || r.jalr || r.br;
        r.rd = (writes && !mis) ? ins[11:7] : 5'd0;
        return r;
    endfunction

    typedef struct {
        logic [31:0] ins, pc, a, b;
        logic [2:0]  redir;   // {jal, jalr, branch}
        logic [1:0]  tsel;    // 0 none, 1 jal, 2 jalr, 3 branch target
        logic [31:0] tgt, imm;
        logic [4:0]  rd;
        logic        ill, exc;
    } vec_t;

    localparam logic [31:0] ADDI = 32'h00500093;   // addi x1,x0,5
    localparam logic [31:0] ADD  = 32'h00128333;   // add x6,x5,x1
    localparam logic [31:0] BEQ  = 32'h00208463;   // beq x1,x2,+8
    localparam logic [31:0] JUNK = 32'h00000FFF;

    vec_t vt[13];

    initial begin
        ref_t r;
        logic mh;
        logic [31:0] mword, ins_seen, rnd;
        logic ev_known, ef_known, e_valid, e_ill, e_exc;
        logic [31:0] e_pc, e_ppf, e_instr, e_a, e_b, e_imm;
        logic [4:0] e_rd;
        logic [6:0] ops[12];

        vt[0]  = '{ADDI, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 32'd5, 5'd1, 1'b0, 1'b0};
        vt[1]  = '{BEQ, 32'h10, 32'd7, 32'd7, 3'b001, 2'd3, 32'h18, 32'd8, 5'd0, 1'b0, 1'b0};
`ifdef CTRL_MISALIGN_EXC_EN
        vt[2]  = '{32'h000080E7, 32'h40, 32'h103, 32'h0, 3'b000, 2'd2, 32'h102, 32'h0, 5'd0, 1'b0, 1'b1};
        vt[3]  = '{32'h002000EF, 32'h20, 32'h0, 32'h0, 3'b000, 2'd1, 32'h22, 32'd2, 5'd0, 1'b0, 1'b1};
`else
        vt[2]  = '{32'h000080E7, 32'h40, 32'h103, 32'h0, 3'b010, 2'd2, 32'h102, 32'h0, 5'd1, 1'b0, 1'b0};
        vt[3]  = '{32'h002000EF, 32'h20, 32'h0, 32'h0, 3'b100, 2'd1, 32'h22, 32'd2, 5'd1, 1'b0, 1'b0};
`endif
        vt[4]  = '{32'h00209463, 32'h10, 32'd7, 32'd7, 3'b000, 2'd3, 32'h18, 32'd8, 5'd0, 1'b0, 1'b0};
        vt[5]  = '{32'hFE20CEE3, 32'h100, 32'hFFFFFFFF, 32'd1, 3'b001, 2'd3, 32'hFC, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
        vt[6]  = '{32'hFE20EEE3, 32'h100, 32'hFFFFFFFF, 32'd1, 3'b000, 2'd3, 32'hFC, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
        vt[7]  = '{32'hFE20AEE3, 32'h100, 32'hFFFFFFFF, 32'd1, 3'b000, 2'd3, 32'hFC, 32'hFFFFFFFC, 5'd0, 1'b1, 1'b0};
        vt[8]  = '{32'h123451B7, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 32'h12345000, 5'd3, 1'b0, 1'b0};
        vt[9]  = '{32'hFE20AE23, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0};
        vt[10] = '{JUNK, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0};
        vt[11] = '{32'hFFFFF297, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, 32'h0, 32'hFFFFF000, 5'd5, 1'b0, 1'b0};
        vt[12] = '{32'h000090E7, 32'h0, 32'h100, 32'h0, 3'b000, 2'd0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0};

        // Reset state
        rst_ni = 1'b0;
        drive(1'b0, 32'h0, ADD, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick(); tick();
        chk("reset_valid", {31'h0, id_ex_valid_o}, 32'h0);
        chk("reset_instr", id_ex_instr_o, 32'h0);
        chk("reset_pc", id_ex_pc_o, 32'h0);
        chk("reset_imm", id_ex_imm_o, 32'h0);
        chk("reset_rd_flags", {25'h0, id_ex_rd_o, id_ex_illegal_o, id_ex_exc_o}, 32'h0);
        chk("reset_live_rs1", {27'h0, rs1_addr_o}, 32'd5);
        rst_ni = 1'b1;

        // Directed vectors, each from the LIVE state with no stall
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vt[i].pc, vt[i].ins, vt[i].a, vt[i].b, 1'b0, 5'd0, 1'b0);
            chk($sformatf("vec%0d_redir", i), {27'h0, instr_jal_o, instr_jalr_o, branch_taken_o, squash_o, stall_o},
                {27'h0, vt[i].redir, |vt[i].redir, 1'b0});
            if (vt[i].tsel != 2'd0)
                chk($sformatf("vec%0d_target", i),
                    vt[i].tsel == 2'd1 ? jal_addr_o : vt[i].tsel == 2'd2 ? jalr_addr_o : branch_addr_o, vt[i].tgt);
            tick();
            chk($sformatf("vec%0d_imm", i), id_ex_imm_o, vt[i].imm);
            chk($sformatf("vec%0d_rd_flags", i), {24'h0, id_ex_valid_o, id_ex_rd_o, id_ex_illegal_o, id_ex_exc_o},
                {24'h0, 1'b1, vt[i].rd, vt[i].ill, vt[i].exc});
            chk($sformatf("vec%0d_instr", i), id_ex_instr_o, vt[i].ins);
        end

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        drive(1'b1, 32'h50, ADD, 32'd11, 32'd22, 1'b1, 5'd5, 1'b0);
        chk("lu_stall", {30'h0, stall_o, squash_o}, 32'h2);
        tick();
        chk("lu_bubble", {31'h0, id_ex_valid_o}, 32'h0);
        drive(1'b1, 32'h50, ADDI, 32'd11, 32'd22, 1'b0, 5'd0, 1'b0);
        chk("lu_release", {26'h0, stall_o, rs1_addr_o}, {26'h0, 1'b0, 5'd5});
        tick();
        chk("lu_issue", {26'h0, id_ex_valid_o, id_ex_rd_o}, {26'h0, 1'b1, 5'd6});
        chk("lu_issue_instr", id_ex_instr_o, ADD);
        drive(1'b1, 32'h54, ADDI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("lu_live_again", {27'h0, rs1_addr_o}, 32'd0);
        tick();
        chk("lu_next_instr", id_ex_instr_o, ADDI);

        // Backpressure for 3 cycles with a taken beq waiting in ID
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h10, c == 0 ? BEQ : JUNK, 32'd7, 32'd7, 1'b0, 5'd0, 1'b1);
            chk($sformatf("bp%0d_noredir", c), {26'h0, rs2_addr_o, squash_o | branch_taken_o},
                {26'h0, 5'd2, 1'b0});
            tick();
            chk($sformatf("bp%0d_frozen", c), id_ex_instr_o, ADDI);
        end
        drive(1'b1, 32'h10, JUNK, 32'd7, 32'd7, 1'b0, 5'd0, 1'b0);
        chk("bp_release_redir", {30'h0, branch_taken_o, squash_o}, 32'h3);
        chk("bp_release_addr", branch_addr_o, 32'h18);
        tick();
        chk("bp_release_instr", id_ex_instr_o, BEQ);

        // Reset while HELD: first post-reset instruction must come from imem
        drive(1'b1, 32'h60, ADD, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        tick();
        rst_ni = 1'b0;
        drive(1'b0, 32'h60, ADDI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1);
        tick();
        rst_ni = 1'b1;
        drive(1'b1, 32'h60, ADDI, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
        chk("rst_mid_live", {27'h0, rs1_addr_o}, 32'd0);
        tick();
        chk("rst_mid_instr", id_ex_instr_o, ADDI);

        // Random traffic against the reference model
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
        mh = 1'b0; mword = 32'h0; ev_known = 1'b0; ef_known = 1'b0;
        e_valid = 0; e_ill = 0; e_exc = 0; e_pc = 0; e_ppf = 0; e_instr = 0; e_a = 0; e_b = 0; e_imm = 0; e_rd = 0;
        for (int n = 0; n < 2000; n++) begin
            logic v, exr, bs;
            logic [31:0] pc, ins, a, b;
            logic [4:0] exrd;
            rnd  = $urandom();
            ins  = {rnd[31:7], ops[$urandom_range(0, 11)]};
            ins_seen = mh ? mword : ins;
            v    = ($urandom_range(0, 9) != 0);
            pc   = {$urandom_range(0, 32'hFFFF), 2'b00} + ($urandom_range(0, 3) == 0 ? 32'd2 : 32'd0);
            a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
            b    = ($urandom_range(0, 1) == 0) ? a : $urandom();
            exr  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: exrd = ins_seen[19:15];
                1: exrd = ins_seen[24:20];
                2: exrd = 5'd0;
                default: exrd = 5'($urandom_range(0, 31));
            endcase
            bs   = ($urandom_range(0, 6) == 0);
            drive(v, pc, ins, a, b, exr, exrd, bs);
            r = ref_decode(ins_seen, pc, a, b, v, exr, exrd, bs);
            chk("rnd_ctrl", {26'h0, rs1_addr_o == ins_seen[19:15], stall_o, squash_o, instr_jal_o, instr_jalr_o, branch_taken_o},
                {26'h0, 1'b1, r.stall, r.squash, r.jal, r.jalr, r.br});
            chk("rnd_jal_addr", jal_addr_o, r.jal_a);
            chk("rnd_jalr_addr", jalr_addr_o, r.jalr_a);
            chk("rnd_br_addr", branch_addr_o, r.br_a);
            if (r.stall) begin
                if (!mh) mword = ins;
                mh = 1'b1;
            end else begin
                mh = 1'b0;
            end
            if (!bs) begin
                ev_known = 1'b1;
                if (r.lu) begin
                    e_valid = 1'b0; ef_known = 1'b0;
                end else begin
                    e_valid = v; ef_known = 1'b1;
                    e_pc = pc; e_ppf = pc + 32'd4; e_instr = ins_seen; e_a = a; e_b = b;
                    e_imm = r.imm; e_rd = r.rd; e_ill = r.ill; e_exc = r.exc;
                end
            end
            tick();
            if (ev_known) chk("rnd_idex_valid", {31'h0, id_ex_valid_o}, {31'h0, e_valid});
            if (ef_known) begin
                chk("rnd_idex_instr", id_ex_instr_o, e_instr);
                chk("rnd_idex_pc", id_ex_pc_o ^ id_ex_pc_plus_four_o, e_pc ^ e_ppf);
                chk("rnd_idex_data", id_ex_rs1_data_o ^ {id_ex_rs2_data_o[15:0], id_ex_rs2_data_o[31:16]},
                    e_a ^ {e_b[15:0], e_b[31:16]});
                chk("rnd_idex_imm", id_ex_imm_o, e_imm);
                chk("rnd_idex_rd", {25'h0, id_ex_rd_o, id_ex_illegal_o, id_ex_exc_o}, {25'h0, e_rd, e_ill, e_exc});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
